// File: rtl/gf_red_pkg.sv
// Shared types and width helpers for the GF(2^m) reduction scheduler and its arbiter.
package gf_red_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_CLEAR
    } gf_state_e;

    function automatic int grade_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // A single requester still needs a 1-bit id field.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DATA_WIDTH_DEF = 4;
    localparam int NUM_REQ_DEF    = 2;
    localparam int GRADE_W        = grade_w(DATA_WIDTH_DEF);
    localparam int ID_W           = id_w(NUM_REQ_DEF);

endpackage

// File: rtl/gf_red_sched_if.sv
// Requester/response bus of the reduction scheduler; packed per-requester operand fields.
interface gf_red_sched_if
    import gf_red_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 2
);
    localparam int GW = grade_w(DATA_WIDTH);
    localparam int IW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ*GW-1:0]             req_grade;
    logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_poly;
    logic [NUM_REQ*2*DATA_WIDTH-1:0]   req_data;
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [IW-1:0]                     rsp_id;
    logic [DATA_WIDTH-1:0]             rsp_data;
    logic                              rsp_err;

    modport master (
        output req_valid, req_grade, req_poly, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_grade, req_poly, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/gf_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins, wrapping to index 0.
module gf_rr_arbiter
    import gf_red_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [id_w(NUM_REQ)-1:0]   grant_idx
);
    localparam int IW = id_w(NUM_REQ);

    logic [IW-1:0] ptr;
    logic          found;

    // First pass covers indices at/above the pointer, second pass handles the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i >= int'(ptr))) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IW'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/gf_red_sched.sv
// Shares one sequential GF(2^m) reduction unit between requesters; returns result plus requester id.
// Build option GF_GRADE_CHECK_EN: out-of-range grades are answered with rsp_err and never reach the unit.
module gf_red_sched
    import gf_red_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_REQ     = 2,
    parameter int RED_LATENCY = DATA_WIDTH + 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    gf_red_sched_if.slave                bus,
    output logic                         busy,
    output logic                         red_op_enable,
    output logic [$clog2(DATA_WIDTH):0]  red_polyn_grade,
    output logic [DATA_WIDTH:0]          red_polyn_red_in,
    output logic [2*DATA_WIDTH-1:0]      red_reduc_in,
    input  logic [DATA_WIDTH-1:0]        red_out
);
    // state | meaning
    // IDLE  | arbitrating, req_ready live
    // LOAD  | operands on red_* ports, unit still cleared
    // RUN   | unit enabled, latency timer running
    // DONE  | result held on rsp_*, waiting for rsp_ready
    // CLEAR | one cycle with enable low to flush the unit

    localparam int GW = grade_w(DATA_WIDTH);
    localparam int IW = id_w(NUM_REQ);
    localparam int PW = DATA_WIDTH + 1;
    localparam int XW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(RED_LATENCY + 1);

    gf_state_e               state;
    gf_state_e               state_nxt;
    logic [NUM_REQ-1:0]      grant;
    logic [IW-1:0]           grant_idx;
    logic                    hs;
    logic                    grade_bad;
    logic [GW-1:0]           win_grade;
    logic [PW-1:0]           win_poly;
    logic [XW-1:0]           win_data;
    logic [GW-1:0]           grade_q;
    logic [PW-1:0]           poly_q;
    logic [XW-1:0]           data_q;
    logic [IW-1:0]           id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [CW-1:0]           cnt;

    gf_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .en        (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign hs = |grant;

    always_comb begin
        win_grade = '0;
        win_poly  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_grade = bus.req_grade[i*GW +: GW];
                win_poly  = bus.req_poly[i*PW +: PW];
                win_data  = bus.req_data[i*XW +: XW];
            end
        end
    end

`ifdef GF_GRADE_CHECK_EN
    logic err_q;

    assign grade_bad   = (win_grade < GW'(2)) || (win_grade > GW'(DATA_WIDTH));
    assign bus.rsp_err = err_q & (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && hs) begin
            err_q <= grade_bad;
        end
    end
`else
    assign grade_bad   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A rejected grade skips the unit entirely and answers straight from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs) state_nxt = grade_bad ? ST_DONE : ST_LOAD;
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN:   if (cnt == CW'(1)) state_nxt = ST_DONE;
            ST_DONE:  if (bus.rsp_ready) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grade_q    <= '0;
            poly_q     <= '0;
            data_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        grade_q    <= win_grade;
                        poly_q     <= win_poly;
                        data_q     <= win_data;
                        id_q       <= grant_idx;
                        rsp_data_q <= '0;
                    end
                end
                ST_LOAD: cnt <= CW'(RED_LATENCY);
                ST_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) rsp_data_q <= red_out;
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.req_ready    = grant;
    assign bus.rsp_valid    = (state == ST_DONE);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign busy             = (state != ST_IDLE);
    assign red_op_enable    = (state == ST_RUN);
    assign red_polyn_grade  = grade_q;
    assign red_polyn_red_in = poly_q;
    assign red_reduc_in     = data_q;

endmodule

// File: tb/tb_gf_red_sched.sv
// Scoreboard bench for gf_red_sched with a behavioural fixed-latency reduction unit (DATA_WIDTH=4).
module tb_gf_red_sched;
    import gf_red_pkg::*;

    localparam int DW = 4;
    localparam int NR = 2;
    localparam int L  = DW + 5;
    localparam int GW = 3;

    typedef struct {
        logic [7:0] data;
        logic [2:0] grade;
        logic [3:0] exp;
        logic       err;
    } item_t;

    typedef struct {
        int         id;
        logic [3:0] data;
        logic       err;
        int         gcyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf_red_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    logic              busy;
    logic              red_op_enable;
    logic [GW-1:0]     red_polyn_grade;
    logic [DW:0]       red_polyn_red_in;
    logic [2*DW-1:0]   red_reduc_in;
    logic [DW-1:0]     red_out;

    gf_red_sched #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .RED_LATENCY (L)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus.slave),
        .busy             (busy),
        .red_op_enable    (red_op_enable),
        .red_polyn_grade  (red_polyn_grade),
        .red_polyn_red_in (red_polyn_red_in),
        .red_reduc_in     (red_reduc_in),
        .red_out          (red_out)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ucnt = 0;
    int    en_cycles = 0;
    item_t rq [NR][$];
    exp_t  sb [$];
    int    gid [$];
    int    gcy [$];
    logic  hs [NR];
    logic  prev_valid = 1'b0;

    function automatic logic [3:0] unit_reduce(input logic [7:0] d, input logic [4:0] p,
                                               input logic [2:0] g);
        logic [12:0] acc;
        acc = {5'b0, d};
        for (int i = 7; i >= 0; i--) begin
            if (int'(g) <= i && acc[i]) acc = acc ^ (13'(p) << (i - int'(g)));
        end
        return acc[3:0];
    endfunction

    // Reduction unit model: result appears on the L-th enabled cycle, zero otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (red_op_enable) begin
            ucnt      <= ucnt + 1;
            en_cycles <= en_cycles + 1;
        end else begin
            ucnt <= 0;
        end
    end

    assign red_out = (red_op_enable && ucnt >= L - 1) ?
                     unit_reduce(red_reduc_in, red_polyn_red_in, red_polyn_grade) : 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic [2:0] g,
                       input logic [3:0] e, input logic err);
        item_t it;
        it.data  = d;
        it.grade = g;
        it.exp   = e;
        it.err   = err;
        rq[r].push_back(it);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (n < budget && !(rq[0].size() == 0 && rq[1].size() == 0 && sb.size() == 0 && !busy)) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, still busy after %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_high(input string nm, input int budget, input int which);
        int n;
        n = 0;
        while (n < budget && !((which == 0) ? bus.rsp_valid : red_op_enable)) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: signal never rose within %0d cycles", nm, budget);
        end
    endtask

    // Requester driver: presents queue heads, records grants, pushes expected responses.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    hs[i] = 1'b0;
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[i*8 +: 8]  = rq[i][0].data;
                    bus.req_grade[i*3 +: 3] = rq[i][0].grade;
                    bus.req_poly[i*5 +: 5]  = 5'b10011;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            #1;
            if (rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        hs[i] = 1'b1;
                        sb.push_back('{id: i, data: rq[i][0].exp, err: rq[i][0].err,
                                       gcyc: cyc, lat: (rq[i][0].err ? 1 : L + 2)});
                        gid.push_back(i);
                        gcy.push_back(cyc);
                    end
                end
            end
        end
    end

    // Response monitor: compares every presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                chk("grant_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
                chk("grant_outside_idle", 32'(busy & (|bus.req_ready)), 32'd0);
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: got id=%0d data=%0h expected none",
                                 bus.rsp_id, bus.rsp_data);
                    end else begin
                        if (!prev_valid) chk("rsp_latency", 32'(cyc - sb[0].gcyc), 32'(sb[0].lat));
                        chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
                        chk("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(sb[0].err));
                        if (bus.rsp_ready) void'(sb.pop_front());
                    end
                end
                prev_valid = bus.rsp_valid;
            end
        end
    end

    initial begin
        int r;
        int en0;
        hs[0]         = 1'b0;
        hs[1]         = 1'b0;
        bus.req_valid = '0;
        bus.req_grade = '0;
        bus.req_poly  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({busy, red_op_enable, bus.rsp_valid, bus.rsp_err}), 32'd0);
        chk("reset_rsp", 32'({bus.rsp_id, bus.rsp_data, bus.req_ready}), 32'd0);
        chk("reset_unit_ports", 32'({red_polyn_grade, red_polyn_red_in, red_reduc_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // x^6 mod x^4+x+1 = x^3+x^2
        add(0, 8'b0100_0000, 3'd4, 4'b1100, 1'b0);
        wait_drain("t1", 60);

        // zero product; also moves the pointer back to requester 0
        add(1, 8'h00, 3'd4, 4'h0, 1'b0);
        wait_drain("t5_zero", 60);

        gid.delete();
        gcy.delete();
        add(0, 8'b0100_0000, 3'd4, 4'b1100, 1'b0);
        add(0, 8'hFF,        3'd4, 4'b1101, 1'b0);
        add(1, 8'b0001_0000, 3'd4, 4'b0011, 1'b0);
        add(1, 8'b1000_0000, 3'd4, 4'b1011, 1'b0);
        wait_drain("t2", 200);
        chk("t2_count", 32'(gid.size()), 32'd4);
        for (int k = 0; k < 4 && k < gid.size(); k++) chk("t2_order", 32'(gid[k]), 32'(k % 2));
        for (int k = 1; k < 4 && k < gid.size(); k++) chk("t2_spacing", 32'(gcy[k] - gcy[k-1]), 32'(L + 4));

        gid.delete();
        gcy.delete();
        bus.rsp_ready = 1'b0;
        add(0, 8'b0010_0000, 3'd4, 4'b0110, 1'b0);
        add(1, 8'b0001_0000, 3'd4, 4'b0011, 1'b0);
        wait_high("t3_valid", 40, 0);
        repeat (20) begin
            @(negedge clk);
            #3;
            chk("t3_no_grant", 32'(bus.req_ready), 32'd0);
            chk("t3_valid_held", 32'(bus.rsp_valid), 32'd1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        r = cyc;
        wait_drain("t3", 60);
        chk("t3_grants", 32'(gid.size()), 32'd2);
        if (gid.size() == 2) begin
            chk("t3_next_id", 32'(gid[1]), 32'd1);
            chk("t3_next_grant", 32'(gcy[1]), 32'(r + 2));
        end

        add(0, 8'b0100_0000, 3'd4, 4'b1100, 1'b0);
        wait_high("t4_run", 40, 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_enable_async", 32'(red_op_enable), 32'd0);
        chk("t4_ctrl_async", 32'({busy, bus.rsp_valid, bus.rsp_err}), 32'd0);
        chk("t4_rsp_async", 32'({bus.rsp_id, bus.rsp_data}), 32'd0);
        chk("t4_ports_async", 32'({red_polyn_grade, red_polyn_red_in, red_reduc_in}), 32'd0);
        sb.delete();
        rq[0].delete();
        rq[1].delete();
        hs[0] = 1'b0;
        hs[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // x^4 = x+1
        add(0, 8'b0001_0000, 3'd4, 4'b0011, 1'b0);
        wait_drain("t4_fresh", 60);

`ifdef GF_GRADE_CHECK_EN
        en0 = en_cycles;
        add(0, 8'b0100_0000, 3'd1, 4'h0, 1'b1);
        wait_drain("t6", 20);
        chk("t6_unit_untouched", 32'(en_cycles), 32'(en0));
        add(1, 8'b0100_0000, 3'd4, 4'b1100, 1'b0);
        wait_drain("t6_after", 60);
`else
        en0 = en_cycles;
        add(1, 8'b0100_0000, 3'd4, 4'b1100, 1'b0);
        wait_drain("t7_enable_len", 60);
        chk("t7_enable_len", 32'(en_cycles - en0), 32'(L));
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
